// File: rtl/ctrl_update_queue.sv
// Control-instruction predictor-update queue: multi-requester round-robin push into a circular FIFO, single-port pop.
// Optional stall statistics counter enabled by defining CTRL_UPD_STALL_STATS_EN.
module ctrl_update_queue #(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int TYPE_W  = 2,
  parameter int CTI_W   = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ-1:0][PC_W-1:0]     req_pc_i,
  input  logic [NUM_REQ-1:0][TYPE_W-1:0]   req_type_i,
  input  logic [NUM_REQ-1:0][PC_W-1:0]     req_npc_i,
  input  logic [NUM_REQ-1:0]               req_dir_i,
  input  logic [NUM_REQ-1:0][CTI_W-1:0]    req_cti_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic                             upd_valid_o,
  output logic [PC_W-1:0]                  upd_pc_o,
  output logic [TYPE_W-1:0]                upd_type_o,
  output logic [PC_W-1:0]                  upd_npc_o,
  output logic                             upd_dir_o,
  output logic [CTI_W-1:0]                 upd_cti_o,
  input  logic                             upd_ready_i,
  output logic [$clog2(DEPTH):0]           count_o
`ifdef CTRL_UPD_STALL_STATS_EN
  ,
  output logic [15:0]                      stall_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [TYPE_W-1:0] mem_type [DEPTH];
  logic [PC_W-1:0]   mem_npc  [DEPTH];
  logic              mem_dir  [DEPTH];
  logic [CTI_W-1:0]  mem_cti  [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [RW-1:0] rr_ptr, rr_next;
  logic          rr_update;

  // Last presented head, so the update port holds its data while the queue is empty.
  logic [PC_W-1:0]   last_pc, last_npc;
  logic [TYPE_W-1:0] last_type;
  logic              last_dir;
  logic [CTI_W-1:0]  last_cti;

  logic              pop;
  logic [CW-1:0]     push_cnt;
  logic [NUM_REQ-1:0] accept;
  logic [AW-1:0]     slot_off [NUM_REQ];

  assign upd_valid_o = (count != '0);
  assign pop         = upd_valid_o & upd_ready_i;
  assign count_o     = count;

  assign upd_pc_o   = upd_valid_o ? mem_pc[rd_ptr]   : last_pc;
  assign upd_type_o = upd_valid_o ? mem_type[rd_ptr] : last_type;
  assign upd_npc_o  = upd_valid_o ? mem_npc[rd_ptr]  : last_npc;
  assign upd_dir_o  = upd_valid_o ? mem_dir[rd_ptr]  : last_dir;
  assign upd_cti_o  = upd_valid_o ? mem_cti[rd_ptr]  : last_cti;

  // Scan requesters from rr_ptr; each position is ready while a slot remains for it.
  always_comb begin
    int            free_slots;
    int            used;
    logic [RW-1:0] idx;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    req_ready_o = '0;
    accept      = '0;
    rr_next     = rr_ptr;
    rr_update   = 1'b0;
    used        = 0;
    idx         = '0;
    for (int r = 0; r < NUM_REQ; r++) slot_off[r] = '0;
    free_slots = DEPTH - int'(count) + int'(pop);
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = RW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!flush_i && used < free_slots) begin
        req_ready_o[idx] = 1'b1;
        if (req_valid_i[idx]) begin
          accept[idx]   = 1'b1;
          slot_off[idx] = AW'(used);
          used          = used + 1;
        end
      end else if (req_valid_i[idx] && !rr_update) begin
        rr_update = 1'b1;
        rr_next   = idx;
      end
    end
    push_cnt = CW'(used);
  end

  // NOTE: storage is cleared on reset because the block requires zeroed entries after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      rr_ptr    <= '0;
      last_pc   <= '0;
      last_type <= '0;
      last_npc  <= '0;
      last_dir  <= 1'b0;
      last_cti  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]   <= '0;
        mem_type[i] <= '0;
        mem_npc[i]  <= '0;
        mem_dir[i]  <= 1'b0;
        mem_cti[i]  <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (upd_valid_o) begin
        last_pc   <= mem_pc[rd_ptr];
        last_type <= mem_type[rd_ptr];
        last_npc  <= mem_npc[rd_ptr];
        last_dir  <= mem_dir[rd_ptr];
        last_cti  <= mem_cti[rd_ptr];
      end
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (rr_update) rr_ptr <= rr_next;
        for (int r = 0; r < NUM_REQ; r++) begin
          if (accept[r]) begin
            mem_pc[wr_ptr + slot_off[r]]   <= req_pc_i[r];
            mem_type[wr_ptr + slot_off[r]] <= req_type_i[r];
            mem_npc[wr_ptr + slot_off[r]]  <= req_npc_i[r];
            mem_dir[wr_ptr + slot_off[r]]  <= req_dir_i[r];
            mem_cti[wr_ptr + slot_off[r]]  <= req_cti_i[r];
          end
        end
        wr_ptr <= wr_ptr + AW'(push_cnt);
        rd_ptr <= rd_ptr + AW'(pop);
        count  <= count + push_cnt - CW'(pop);
      end
    end
  end

`ifdef CTRL_UPD_STALL_STATS_EN
  logic stall;
  assign stall = |(req_valid_i & ~req_ready_o);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_o <= '0;
    end else if (stall && stall_cnt_o != 16'hFFFF) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_update_queue.sv
// Scoreboard bench for ctrl_update_queue: a queue model predicts grants and FIFO contents,
// a negedge monitor compares every presented update record in order.
module tb_ctrl_update_queue;

  localparam int NUM_REQ = 2;
  localparam int DEPTH   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  typ;
    logic [31:0] npc;
    logic        dir;
    logic [3:0]  cti;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0][31:0]  req_pc;
  logic [NUM_REQ-1:0][1:0]   req_type;
  logic [NUM_REQ-1:0][31:0]  req_npc;
  logic [NUM_REQ-1:0]        req_dir;
  logic [NUM_REQ-1:0][3:0]   req_cti;
  logic [NUM_REQ-1:0]        req_ready;
  logic        upd_valid, upd_dir, upd_ready;
  logic [31:0] upd_pc, upd_npc;
  logic [1:0]  upd_type;
  logic [3:0]  upd_cti;
  logic [2:0]  count;
`ifdef CTRL_UPD_STALL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  ctrl_update_queue #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH), .PC_W(32), .TYPE_W(2), .CTI_W(4)) dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .req_valid_i(req_valid), .req_pc_i(req_pc), .req_type_i(req_type),
    .req_npc_i(req_npc), .req_dir_i(req_dir), .req_cti_i(req_cti),
    .req_ready_o(req_ready),
    .upd_valid_o(upd_valid), .upd_pc_o(upd_pc), .upd_type_o(upd_type),
    .upd_npc_o(upd_npc), .upd_dir_o(upd_dir), .upd_cti_o(upd_cti),
    .upd_ready_i(upd_ready), .count_o(count)
`ifdef CTRL_UPD_STALL_STATS_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  rec_t exp_q[$];
  rec_t last_rec = '0;
  int   rr = 0;
  int   stall_m = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t input_rec(input int r);
    rec_t x;
    x.pc  = req_pc[r];
    x.typ = req_type[r];
    x.npc = req_npc[r];
    x.dir = req_dir[r];
    x.cti = req_cti[r];
    return x;
  endfunction

  // Monitor: compares the presented head against the scoreboard and retires it on a handshake.
  initial begin
    rec_t head;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("upd_valid", {63'd0, upd_valid}, {63'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
          head = exp_q[0];
          check("upd_pc", {32'd0, upd_pc}, {32'd0, head.pc});
          check("upd_npc", {32'd0, upd_npc}, {32'd0, head.npc});
          check("upd_meta", {57'd0, upd_type, upd_dir, upd_cti}, {57'd0, head.typ, head.dir, head.cti});
          last_rec = head;
          if (upd_ready) void'(exp_q.pop_front());
        end else begin
          check("hold_pc", {32'd0, upd_pc}, {32'd0, last_rec.pc});
          check("hold_meta", {57'd0, upd_type, upd_dir, upd_cti},
                {57'd0, last_rec.typ, last_rec.dir, last_rec.cti});
        end
      end
    end
  end

  // One cycle of stimulus, entered shortly after a rising edge.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic ur, input logic fl, input bit keep_data);
    int cnt, free_slots, used, first_denied, r;
    bit pop;
    logic [NUM_REQ-1:0] exp_ready;
    rec_t acc[$];
    if (!keep_data) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_pc[i]   = $urandom;
        req_type[i] = 2'($urandom_range(0, 3));
        req_npc[i]  = $urandom;
        req_dir[i]  = 1'($urandom_range(0, 1));
        req_cti[i]  = 4'($urandom_range(0, 15));
      end
    end
    req_valid = v;
    upd_ready = ur;
    flush     = fl;
    #1;
    cnt          = exp_q.size();
    pop          = (cnt != 0) && ur;
    free_slots   = DEPTH - cnt + int'(pop);
    used         = 0;
    first_denied = -1;
    exp_ready    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      r = (rr + k) % NUM_REQ;
      if (!fl && used < free_slots) begin
        exp_ready[r] = 1'b1;
        if (v[r]) begin
          acc.push_back(input_rec(r));
          used++;
        end
      end else if (v[r] && first_denied < 0) begin
        first_denied = r;
      end
    end
    check("req_ready", {62'd0, req_ready}, {62'd0, exp_ready});
    check("count", {61'd0, count}, 64'(cnt));
    if ((v & ~exp_ready) != '0 && stall_m < 65535) stall_m++;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      foreach (acc[i]) exp_q.push_back(acc[i]);
      if (first_denied >= 0) rr = first_denied;
    end
    #1;
`ifdef CTRL_UPD_STALL_STATS_EN
    check("stall_cnt", {48'd0, stall_cnt}, 64'(stall_m));
`endif
  endtask

  // Asynchronous reset asserted between edges; effects are checked before the next edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    req_valid = '0;
    flush = 1'b0;
    upd_ready = 1'b0;
    #1;
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_valid", {63'd0, upd_valid}, 64'd0);
    check("rst_pc", {32'd0, upd_pc}, 64'd0);
`ifdef CTRL_UPD_STALL_STATS_EN
    check("rst_stall", {48'd0, stall_cnt}, 64'd0);
`endif
    exp_q.delete();
    last_rec = '0;
    rr = 0;
    stall_m = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    upd_ready = 1'b0;
    req_pc = '0; req_type = '0; req_npc = '0; req_dir = '0; req_cti = '0;
    #2;
    check("init_count", {61'd0, count}, 64'd0);
    check("init_valid", {63'd0, upd_valid}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single record with fixed contents, popped immediately.
    req_pc[0] = 32'h1000; req_npc[0] = 32'h1040; req_dir[0] = 1'b1; req_cti[0] = 4'd3; req_type[0] = 2'd2;
    step(2'b01, 1'b1, 1'b0, 1'b1);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);

    // Fill with both requesters while the consumer stalls, then drain at one per cycle.
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(2'b11, 1'b1, 1'b0, 1'b0);

    // Flush with two entries queued and a valid request pending.
    step(2'b00, 1'b0, 1'b1, 1'b0);
    step(2'b11, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b1, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b0);

    // Six pushes with continuous popping carry the write pointer across the wrap.
    for (int i = 0; i < 6; i++) step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with occasional flushes and consumer back-pressure.
    for (int i = 0; i < 400; i++)
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), 1'b0);

    // Reset in the middle of traffic, then push on the first edge afterwards.
    step(2'b11, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(2'b10, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);

`ifdef CTRL_UPD_STALL_STATS_EN
    do_reset();
    for (int i = 0; i < 2; i++) step(2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(2'b01, 1'b0, 1'b0, 1'b0);
    check("stall_ten", {48'd0, stall_cnt}, 64'd10);
    do_reset();
`endif

    for (int i = 0; i < 100; i++)
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ctrl_update_queue.md
CTRL_UPDATE_QUEUE -- requirements
Module: ctrl_update_queue

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 2, number of control-pipe requesters; DEPTH, default 4, FIFO entries (power of 2, at least 2); PC_W, default 32, PC width; TYPE_W, default 2, branch-type width; CTI_W, default 4, CTI ID width.
REQ-002 SHALL have port: clk  input  1  clock, all state rising-edge.
REQ-003 SHALL have port: reset  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port: flush_i  input  1  recover/exception flush.
REQ-005 SHALL have ports per requester r: req_valid_i[r] input 1; req_pc_i[r] input PC_W; req_type_i[r] input TYPE_W; req_npc_i[r] input PC_W; req_dir_i[r] input 1; req_cti_i[r] input CTI_W.
REQ-006 SHALL have port: req_ready_o  output  NUM_REQ  per-requester accept.
REQ-007 SHALL have ports: upd_valid_o output 1; upd_pc_o, upd_type_o, upd_npc_o, upd_dir_o, upd_cti_o outputs of the same widths as the inputs; upd_ready_i input 1. This is the frontend predictor-update port.
REQ-008 SHALL have port: count_o  output  clog2(DEPTH)+1  occupancy.

Function
REQ-009 SHALL store resolved control-instruction records in a circular FIFO with read pointer, write pointer and count.
REQ-010 SHALL drive upd_* from the head entry. upd_valid_o SHALL equal (count!=0).
REQ-011 pop SHALL equal upd_valid_o AND upd_ready_i. The head advances at the clock edge.
REQ-012 free SHALL equal DEPTH - count + pop. A slot freed by pop is reusable in the same cycle.
REQ-013 Acceptance SHALL be combinational. Valid requesters are scanned in priority order starting at rr_ptr, and the first min(free, number valid) are granted. req_ready_o[r]=1 only for granted r.
REQ-014 Requesters that are not valid SHALL still receive req_ready_o=1 if a slot would be available to them. Only valid AND ready constitutes an accept.
REQ-015 Accepted records SHALL be written in priority order into consecutive slots, with pointer wrap modulo DEPTH.
REQ-016 rr_ptr SHALL advance to (first denied valid requester) when any valid requester is denied. Otherwise it SHALL be unchanged.
REQ-017 Latency: a record accepted at edge N SHALL be visible on upd_* after edge N if the FIFO was empty. There is no combinational input-to-output path.
REQ-018 Simultaneous push and pop SHALL update count by pushes minus pop.
REQ-019 Full with no pop: all req_ready_o=0, no state change except rr_ptr.
REQ-020 Empty: upd_valid_o=0, and upd_* data SHALL be held at the last values.
REQ-021 flush_i=1 SHALL reset pointers and count to 0 at the next edge and drop the same-cycle pushes. req_ready_o SHALL be forced 0 while flush_i=1, and upd_valid_o is unaffected until the edge.
REQ-022 A record written to the FIFO SHALL be presented unchanged (no reordering, modification or duplication).

Reset
REQ-023 Asserting reset (low) SHALL immediately clear count, pointers and rr_ptr, with upd_valid_o=0 and count_o=0. upd_* data and storage are 0.
REQ-024 Reset mid-operation SHALL discard all entries. No partial record SHALL appear after deassertion.
REQ-025 The first push SHALL be possible on the first edge after deassertion.

Configuration
REQ-026 Macro CTRL_UPD_STALL_STATS_EN defined: SHALL add output stall_cnt_o (16 bits), a saturating count of cycles with any req_valid_i[r]=1 AND req_ready_o[r]=0.
REQ-027 stall_cnt_o SHALL be cleared by reset only (not by flush) and SHALL hold at 0xFFFF.
REQ-028 Macro undefined: no stall_cnt_o port and no counter logic. All other behaviour SHALL be identical.

Verification
REQ-029 Reset, then req0 valid pc=0x1000 npc=0x1040 dir=1 cti=3 for one cycle with upd_ready_i=1: next cycle upd_valid_o=1, upd_pc_o=0x1000, cti=3; following cycle count_o=0.
REQ-030 upd_ready_i=0, both requesters valid every cycle: FIFO fills to 4 in 2 cycles, then req_ready_o=00, count_o=4, and order is req0,req1,req0,req1.
REQ-031 Full, upd_ready_i=1, both valid: exactly one accepted per cycle, alternating req0/req1 by rr_ptr, and count_o stays 4.
REQ-032 Two entries queued, flush_i=1 with req0 valid: req_ready_o=00, and the next cycle has count_o=0 and upd_valid_o=0.
REQ-033 Write pointer wrap: push 6 records while popping continuously: records emerge in order across the index 3->0 boundary.
REQ-034 With CTRL_UPD_STALL_STATS_EN, hold full with req0 valid for 10 cycles: stall_cnt_o=10. Then assert reset low mid-stream: stall_cnt_o=0, count_o=0 immediately.
